hazard_stall_controller: RTL and testbench

- Pipeline sequencing controller that sits beside the instruction decode stage.
- Generates PC/IF-ID write enables, decode bubble and flush strobes (`branch_flush`, `flush_jump`) consumed by the decoder.
- Sequences three event types: load-use hazards, taken branches/jumps, and multi-cycle FFT execution.
- Keeps saturating stall/flush performance counters and a sticky FFT-timeout flag.

---
 rtl/hazard_stall_controller.sv | 149 ++++++++++++++
 tb/tb_hazard_stall_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Decode-side sequencing controller: load-use bubbles, branch/jump flush strobes,
// FFT completion wait with timeout, and saturating stall/flush event counters.
module hazard_stall_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int FFT_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_rs1,
  input  logic [3:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [3:0]       ex_rd,
  input  logic             ex_ld,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             ex_fft,
  input  logic             fft_done,
  input  logic             clr_counters,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             id_bubble,
  output logic             branch_flush,
  output logic             flush_jump,
  output logic             fft_busy,
  output logic             fft_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam int TW  = $clog2(FFT_TIMEOUT + 1);
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);
  localparam logic [TW-1:0]  TMO_LAST   = TW'(FFT_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, FLUSH, FFT_WAIT} state_t;

  state_t           state_q, state_d;
  logic             cause_jump_q, cause_jump_d;
  logic [FCW-1:0]   flush_ctr_q, flush_ctr_d;
  logic [TW-1:0]    fft_timer_q, fft_timer_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic pc_w, ifid_w, bubble, bflush, jflush, flush_ev, load_use;

  assign load_use = ex_ld && (ex_rd != 4'd0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  always_comb begin
    state_d      = state_q;
    cause_jump_d = cause_jump_q;
    flush_ctr_d  = flush_ctr_q;
    fft_timer_d  = fft_timer_q;
    timeout_d    = timeout_q;
    pc_w         = 1'b1;
    ifid_w       = 1'b1;
    bubble       = 1'b0;
    bflush       = 1'b0;
    jflush       = 1'b0;
    flush_ev     = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_jump || ex_branch_taken) begin
          jflush   = ex_jump;
          bflush   = !ex_jump;
          flush_ev = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            cause_jump_d = ex_jump;
            flush_ctr_d  = FLUSH_LOAD;
            state_d      = FLUSH;
          end
        end else if (ex_fft) begin
          pc_w        = 1'b0;
          ifid_w      = 1'b0;
          fft_timer_d = '0;
          state_d     = FFT_WAIT;
        end else if (load_use) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          bubble = 1'b1;
        end
      end
      FLUSH: begin
        // EX events arriving here belong to squashed instructions
        jflush      = cause_jump_q;
        bflush      = !cause_jump_q;
        flush_ctr_d = flush_ctr_q - 1'b1;
        if (flush_ctr_q == FCW'(1)) state_d = RUN;
      end
      FFT_WAIT: begin
        fft_timer_d = fft_timer_q + 1'b1;
        if (fft_done) begin
          state_d = RUN;
        end else begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          if (fft_timer_q == TMO_LAST) begin
            timeout_d = 1'b1;
            state_d   = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase

    if (clr_counters) begin
      stall_d     = '0;
      flush_cnt_d = '0;
      timeout_d   = 1'b0;
    end else begin
      stall_d     = (!pc_w && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
      flush_cnt_d = (flush_ev && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      cause_jump_q <= 1'b0;
      flush_ctr_q  <= '0;
      fft_timer_q  <= '0;
      timeout_q    <= 1'b0;
      stall_q      <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cause_jump_q <= cause_jump_d;
      flush_ctr_q  <= flush_ctr_d;
      fft_timer_q  <= fft_timer_d;
      timeout_q    <= timeout_d;
      stall_q      <= stall_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Every output reads as zero for the whole time reset is held
  assign pc_write     = pc_w   & ~reset;
  assign ifid_write   = ifid_w & ~reset;
  assign id_bubble    = bubble & ~reset;
  assign branch_flush = bflush & ~reset;
  assign flush_jump   = jflush & ~reset;
  assign fft_busy     = (state_q == FFT_WAIT) & ~reset;
  assign fft_timeout  = timeout_q & ~reset;
  assign stall_count  = stall_q & {CNT_W{~reset}};
  assign flush_count  = flush_cnt_q & {CNT_W{~reset}};

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed scenarios followed by random traffic,
// every cycle compared against a cycle-count based behavioural model.
module tb_hazard_stall_controller;

  localparam int FLUSH_CYCLES = 2;
  localparam int FFT_TIMEOUT  = 12;
  localparam int CW           = 4;
  localparam int CNT_MAX      = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, uses2, ld, br, jmp, fft, done, clr;
  logic [3:0] rs1, rs2, rd;
  logic pc_write, ifid_write, id_bubble, branch_flush, flush_jump, fft_busy, fft_timeout;
  logic [CW-1:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  // Model state: remaining held flush cycles, FFT wait progress, sticky flag, counts
  int m_flush_left = 0;
  bit m_jump       = 0;
  bit m_in_fft     = 0;
  int m_fft_elapsed = 0;
  bit m_timeout    = 0;
  int m_stall      = 0;
  int m_flush      = 0;

  hazard_stall_controller #(
    .FLUSH_CYCLES(FLUSH_CYCLES), .FFT_TIMEOUT(FFT_TIMEOUT), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(rst), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs2(uses2),
    .ex_rd(rd), .ex_ld(ld), .ex_branch_taken(br), .ex_jump(jmp), .ex_fft(fft),
    .fft_done(done), .clr_counters(clr), .pc_write(pc_write), .ifid_write(ifid_write),
    .id_bubble(id_bubble), .branch_flush(branch_flush), .flush_jump(flush_jump),
    .fft_busy(fft_busy), .fft_timeout(fft_timeout), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; uses2 = 0; ld = 0; br = 0; jmp = 0; fft = 0; done = 0; clr = 0;
    rs1 = 0; rs2 = 0; rd = 0;
  endtask

  // One clock: check outputs for the current inputs, then advance the model over the edge
  task automatic step(input string tag);
    logic e_pc, e_if, e_bub, e_bf, e_fj, e_busy, e_tmo, hz, flush_ev;
    int e_stall, e_flush;
    #2;
    hz = ld && (rd != 0) && (rd == rs1 || (uses2 && rd == rs2));
    e_pc = 1; e_if = 1; e_bub = 0; e_bf = 0; e_fj = 0; flush_ev = 0;
    if (m_flush_left > 0) begin
      e_fj = m_jump; e_bf = !m_jump;
    end else if (m_in_fft) begin
      e_pc = done; e_if = done;
    end else if (jmp || br) begin
      e_fj = jmp; e_bf = !jmp; flush_ev = 1;
    end else if (fft) begin
      e_pc = 0; e_if = 0;
    end else if (hz) begin
      e_pc = 0; e_if = 0; e_bub = 1;
    end
    e_busy = m_in_fft; e_tmo = m_timeout; e_stall = m_stall; e_flush = m_flush;
    if (rst) begin
      e_pc = 0; e_if = 0; e_bub = 0; e_bf = 0; e_fj = 0;
      e_busy = 0; e_tmo = 0; e_stall = 0; e_flush = 0;
    end
    chk({tag, ".ctl"},
        32'({pc_write, ifid_write, id_bubble, branch_flush, flush_jump, fft_busy, fft_timeout}),
        32'({e_pc, e_if, e_bub, e_bf, e_fj, e_busy, e_tmo}));
    chk({tag, ".stall"}, 32'(stall_count), 32'(e_stall));
    chk({tag, ".flush"}, 32'(flush_count), 32'(e_flush));
    @(posedge clk);
    if (rst) begin
      m_flush_left = 0; m_jump = 0; m_in_fft = 0; m_fft_elapsed = 0;
      m_timeout = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc && m_stall < CNT_MAX) m_stall++;
      if (flush_ev && m_flush < CNT_MAX) m_flush++;
      if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (m_in_fft) begin
        if (done) m_in_fft = 0;
        else if (m_fft_elapsed == FFT_TIMEOUT - 1) begin
          m_in_fft = 0; m_timeout = 1;
        end else m_fft_elapsed++;
      end else if (jmp || br) begin
        m_flush_left = FLUSH_CYCLES - 1; m_jump = jmp;
      end else if (fft) begin
        m_in_fft = 1; m_fft_elapsed = 0;
      end
      if (clr) begin
        m_stall = 0; m_flush = 0; m_timeout = 0;
      end
    end
    #1;
  endtask

  initial begin
    idle();
    // Reset held with competing events pending
    rst = 1; fft = 1; br = 1;
    step("rst0"); step("rst1"); step("rst2");
    chk("rst.pc", 32'(pc_write), 32'd0);
    idle();
    step("run");
    chk("run.pc", 32'(pc_write), 32'd1);
    chk("run.stall0", 32'(stall_count), 32'd0);

    // Load-use detection and its qualifiers
    ld = 1; rd = 5; rs1 = 5;
    step("lu.hit");
    idle(); step("lu.after");
    chk("lu.stall1", 32'(stall_count), 32'd1);
    ld = 1; rd = 0; rs1 = 0; step("lu.x0");
    ld = 1; rd = 5; rs1 = 3; rs2 = 5; uses2 = 0; step("lu.norz2");
    uses2 = 1; step("lu.rs2hit");
    idle(); step("lu.end");

    // Branch flush, ignored second branch, jump priority
    br = 1; step("br.c0");
    step("br.c1");
    idle(); step("br.c2");
    chk("br.cnt", 32'(flush_count), 32'd1);
    jmp = 1; br = 1; step("jb.c0");
    idle(); step("jb.c1"); step("jb.c2");

    // FFT completing on cycle 10
    clr = 1; step("clr.a");
    idle(); fft = 1; step("fft.c0");
    fft = 0;
    for (int i = 1; i < 10; i++) step("fft.wait");
    done = 1; step("fft.done");
    idle(); step("fft.end");
    chk("fft.stall10", 32'(stall_count), 32'd10);

    // FFT timeout, then clear
    fft = 1; step("tmo.c0");
    idle();
    for (int i = 0; i < FFT_TIMEOUT; i++) step("tmo.wait");
    step("tmo.run");
    chk("tmo.flag", 32'(fft_timeout), 32'd1);
    chk("tmo.pc", 32'(pc_write), 32'd1);
    clr = 1; step("tmo.clr");
    idle(); step("tmo.cleared");
    chk("tmo.flag0", 32'(fft_timeout), 32'd0);

    // Stall counter saturation
    ld = 1; rd = 7; rs1 = 7;
    for (int i = 0; i < 20; i++) step("sat");
    idle(); step("sat.end");
    chk("sat.stall15", 32'(stall_count), 32'd15);

    // Reset while waiting on FFT
    fft = 1; step("rfft.c0");
    idle(); step("rfft.w1"); step("rfft.w2");
    rst = 1; step("rfft.rst");
    idle(); step("rfft.run");
    chk("rfft.busy", 32'(fft_busy), 32'd0);
    chk("rfft.tmo", 32'(fft_timeout), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 79) == 0);
      clr   = ($urandom_range(0, 31) == 0);
      ld    = $urandom_range(0, 1) == 1;
      rd    = 4'($urandom_range(0, 7));
      rs1   = 4'($urandom_range(0, 7));
      rs2   = 4'($urandom_range(0, 7));
      uses2 = $urandom_range(0, 1) == 1;
      br    = ($urandom_range(0, 7) == 0);
      jmp   = ($urandom_range(0, 15) == 0);
      fft   = ($urandom_range(0, 11) == 0);
      done  = ($urandom_range(0, 9) == 0);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
